demux_byte_stream: RTL
======================

DEMUX_BYTE_STREAM -- requirements
Module: demux_byte_stream

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 2, per-channel FIFO depth in bytes (legal: 2, 4, 8, 16).
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Rst  input  1  synchronous, active-high reset.
REQ-004 Din  input  8  input byte.
REQ-005 Din_valid  input  1  Din holds a byte to transfer.
REQ-006 Din_ready  output  1  block accepts Din this cycle.
REQ-007 Sel  input  1  target channel in select mode (0 -> channel 0, 1 -> channel 1).
REQ-008 Mode  input  1  0 = select mode, 1 = alternate (round-robin) mode.
REQ-009 D_out_0 / D_out_1  output  8 each  head byte of channel 0 / 1 FIFO.
REQ-010 Valid_0 / Valid_1  output  1 each  channel FIFO non-empty.
REQ-011 Ready_0 / Ready_1  input  1 each  downstream consumes the head byte.
REQ-012 Cnt_0 / Cnt_1  output  16 each  accepted-byte counters (present only with DEMUX_BYTE_COUNT_EN).

Function
REQ-013 Target channel T SHALL be Sel when Mode=0 and internal register Turn when Mode=1.
REQ-014 Din_ready SHALL be 1 exactly when FIFO T is not full; a full FIFO popping in the same cycle SHALL NOT assert Din_ready (no pop bypass).
REQ-015 An input transfer occurs on a rising edge with Din_valid=1 and Din_ready=1; Din is written to FIFO T only; the other FIFO is unchanged.
REQ-016 Latency: a byte accepted into an empty FIFO at edge N SHALL appear on D_out_T with Valid_T=1 from edge N (registered, one cycle after presentation), never combinationally.
REQ-017 A channel pop occurs on a rising edge with Valid_k=1 and Ready_k=1; Ready_k with Valid_k=0 SHALL have no effect.
REQ-018 Push and pop on the same FIFO in the same edge SHALL leave its occupancy unchanged and preserve order.
REQ-019 D_out_k SHALL remain stable while Valid_k=1 and Ready_k=0.
REQ-020 Each FIFO SHALL deliver bytes in acceptance order; read/write pointers SHALL wrap modulo DEPTH.
REQ-021 Turn SHALL toggle only on an accepted transfer while Mode=1; a stall (Din_ready=0) SHALL NOT toggle it.
REQ-022 Changing Mode mid-stream SHALL take effect on the next cycle's target computation; Turn SHALL retain its value while Mode=0.
REQ-023 Channels SHALL be fully independent: a stalled channel SHALL NOT block pops on the other, and SHALL block input only when it is the target.

Reset
REQ-024 While Rst=1 on a rising edge: both FIFOs empty, Turn=0, counters 0; contents discarded.
REQ-025 Output reset values: Valid_0=0, Valid_1=0, D_out_0=8'h00, D_out_1=8'h00, Cnt_0=0, Cnt_1=0; Din_ready=1 in the cycle after reset deasserts.
REQ-026 Rst SHALL override any simultaneous push or pop.

Configuration
REQ-027 Macro DEMUX_BYTE_COUNT_EN defined: Cnt_0/Cnt_1 ports exist; each increments by 1 per byte accepted into its channel and saturates at 16'hFFFF.
REQ-028 Macro DEMUX_BYTE_COUNT_EN undefined: Cnt_0/Cnt_1 ports and counter logic are absent; all other behaviour identical.

Verification
REQ-029 Reset, Mode=0, Sel=1, push 8'hA5, Ready_1=1 -> Valid_1=1 with D_out_1=8'hA5 for one cycle, channel 0 stays Valid_0=0.
REQ-030 DEPTH=2, Mode=0, Sel=0, Ready_0=0, push 8'h01,8'h02,8'h03 -> third byte stalls (Din_ready=0); releasing Ready_0 yields 01,02,03 in order.
REQ-031 Mode=1, push 8'h10..8'h15 with both Ready=1 -> channel 0 gets 10,12,14; channel 1 gets 11,13,15.
REQ-032 Mode=1, Ready_1=0, channel 1 full, Turn=1 -> Din_ready=0, Turn holds; channel 0 pops continue unaffected.
REQ-033 Rst asserted with both FIFOs holding 2 bytes -> next cycle Valid_0=Valid_1=0, Turn=0, Cnt_0=Cnt_1=0.
REQ-034 With DEMUX_BYTE_COUNT_EN, 5 bytes to channel 0 and 3 to channel 1 -> Cnt_0=5, Cnt_1=3; forced Cnt_0=16'hFFFF plus one push -> stays 16'hFFFF.

Source files
------------

// File: rtl/demux_byte_stream.sv
// 1:2 byte demultiplexer with one small FIFO per output channel; the target
// channel comes from Sel (select mode) or an internal alternating Turn bit.
// Optional per-channel accepted-byte counters are built when DEMUX_BYTE_COUNT_EN is defined.

module demux_byte_stream_fifo #(
    parameter int DEPTH = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_data  = r_mem[r_rd_ptr];
    // A pop request against an empty FIFO is ignored.
    assign w_pop   = i_pop & o_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && w_pop) r_count <= r_count - 1'b1;
        end
    end
endmodule

module demux_byte_stream #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_din,
    input  logic        i_din_valid,
    output logic        o_din_ready,
    input  logic        i_sel,
    input  logic        i_mode,
    output logic [7:0]  o_d_out_0,
    output logic [7:0]  o_d_out_1,
    output logic        o_valid_0,
    output logic        o_valid_1,
    input  logic        i_ready_0,
    input  logic        i_ready_1
`ifdef DEMUX_BYTE_COUNT_EN
    ,
    output logic [15:0] o_cnt_0,
    output logic [15:0] o_cnt_1
`endif
);
    logic r_turn;
    logic w_target;
    logic w_full_0;
    logic w_full_1;
    logic w_accept;
    logic w_push_0;
    logic w_push_1;

    assign w_target    = i_mode ? r_turn : i_sel;
    // Readiness depends only on the target's fullness, never on a same-cycle pop.
    assign o_din_ready = w_target ? !w_full_1 : !w_full_0;
    assign w_accept    = i_din_valid & o_din_ready;
    assign w_push_0    = w_accept & !w_target;
    assign w_push_1    = w_accept &  w_target;

    always_ff @(posedge i_clk) begin
        if (i_rst)                  r_turn <= 1'b0;
        else if (w_accept && i_mode) r_turn <= ~r_turn;
    end

    demux_byte_stream_fifo #(.DEPTH(DEPTH)) u_fifo_0 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (w_push_0),
        .i_data (i_din),
        .i_pop  (i_ready_0),
        .o_data (o_d_out_0),
        .o_valid(o_valid_0),
        .o_full (w_full_0)
    );

    demux_byte_stream_fifo #(.DEPTH(DEPTH)) u_fifo_1 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (w_push_1),
        .i_data (i_din),
        .i_pop  (i_ready_1),
        .o_data (o_d_out_1),
        .o_valid(o_valid_1),
        .o_full (w_full_1)
    );

`ifdef DEMUX_BYTE_COUNT_EN
    logic [15:0] r_cnt_0;
    logic [15:0] r_cnt_1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt_0 <= '0;
            r_cnt_1 <= '0;
        end else begin
            if (w_push_0 && r_cnt_0 != 16'hFFFF) r_cnt_0 <= r_cnt_0 + 16'd1;
            if (w_push_1 && r_cnt_1 != 16'hFFFF) r_cnt_1 <= r_cnt_1 + 16'd1;
        end
    end

    assign o_cnt_0 = r_cnt_0;
    assign o_cnt_1 = r_cnt_1;
`endif
endmodule
